// File: rtl/eop_line_monitor_if.sv
// Line-sample, flag-clear and status signals of the USB end-of-packet monitor.
interface eop_line_monitor_if;
  logic dataInP;
  logic dataInN;
  logic clearFlags;
  logic eop;
  logic eopPulse;
  logic eopErr;
  logic busReset;

  modport master (
    output dataInP, dataInN, clearFlags,
    input  eop, eopPulse, eopErr, busReset
  );

  modport slave (
    input  dataInP, dataInN, clearFlags,
    output eop, eopPulse, eopErr, busReset
  );
endinterface

// File: rtl/eop_line_monitor.sv
// Watches synchronised D+/D- samples for a well-formed SE0-then-J end of packet,
// flags malformed EOPs and reports long SE0 as bus reset.
//
// state   | meaning
// IDLE    | no SE0 run in progress
// SE0_RUN | counting consecutive SE0 samples
// WAIT_J  | SE0 run of valid length ended on non-J; waiting for J
module eop_line_monitor #(
  parameter int SE0_MIN          = 3,
  parameter int SE0_MAX          = 10,
  parameter int J_WINDOW         = 2,
  parameter int BUS_RESET_CYCLES = 120,
  localparam int CNT_W           = $clog2(BUS_RESET_CYCLES + 1),
  localparam int JCNT_W          = $clog2(J_WINDOW + 1)
) (
  input logic               clk48,
  input logic               RST,
  eop_line_monitor_if.slave bus
);

  if (!(SE0_MIN >= 1 && SE0_MIN <= SE0_MAX && SE0_MAX < BUS_RESET_CYCLES && J_WINDOW >= 1))
  begin : g_bad_params
    $error("eop_line_monitor: need 1<=SE0_MIN<=SE0_MAX<BUS_RESET_CYCLES and J_WINDOW>=1");
  end

  typedef enum logic [1:0] {IDLE, SE0_RUN, WAIT_J} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [JCNT_W-1:0]   jcnt_q, jcnt_d;
  logic                eop_q, eop_d;
  logic                pulse_q, pulse_d;
  logic                err_q, err_d;
  logic                brst_q, brst_d;
  logic                se0, j, set_eop, set_err;

  assign se0 = !bus.dataInP && !bus.dataInN;
  assign j   =  bus.dataInP && !bus.dataInN;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    jcnt_d  = jcnt_q;
    set_eop = 1'b0;
    set_err = 1'b0;
    brst_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (se0) begin
          state_d = SE0_RUN;
          cnt_d   = CNT_W'(1);
        end
      end
      SE0_RUN: begin
        if (se0) begin
          if (cnt_q < CNT_W'(BUS_RESET_CYCLES)) cnt_d = cnt_q + CNT_W'(1);
          // asserted together with the count reaching the bus-reset length
          brst_d = (cnt_q >= CNT_W'(BUS_RESET_CYCLES - 1));
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          if (cnt_q < CNT_W'(SE0_MIN) || cnt_q >= CNT_W'(BUS_RESET_CYCLES)) begin
            state_d = IDLE;
          end else if (cnt_q > CNT_W'(SE0_MAX)) begin
            set_err = 1'b1;
          end else if (j) begin
            set_eop = 1'b1;
          end else begin
            state_d = WAIT_J;
            jcnt_d  = JCNT_W'(1);
          end
        end
      end
      WAIT_J: begin
        if (j) begin
          set_eop = 1'b1;
          state_d = IDLE;
          jcnt_d  = '0;
        end else if (jcnt_q == JCNT_W'(J_WINDOW)) begin
          set_err = 1'b1;
          state_d = IDLE;
          jcnt_d  = '0;
        end else begin
          jcnt_d = jcnt_q + JCNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        jcnt_d  = '0;
      end
    endcase
    // a flag set in the same cycle as a clear takes priority
    eop_d   = set_eop | (eop_q & !bus.clearFlags);
    err_d   = set_err | (err_q & !bus.clearFlags);
    pulse_d = set_eop;
  end

  always_ff @(posedge clk48 or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      jcnt_q  <= '0;
      eop_q   <= 1'b0;
      pulse_q <= 1'b0;
      err_q   <= 1'b0;
      brst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      jcnt_q  <= jcnt_d;
      eop_q   <= eop_d;
      pulse_q <= pulse_d;
      err_q   <= err_d;
      brst_q  <= brst_d;
    end
  end

  assign bus.eop      = eop_q;
  assign bus.eopPulse = pulse_q;
  assign bus.eopErr   = err_q;
  assign bus.busReset = brst_q;

endmodule

// File: tb/tb_eop_line_monitor.sv
// Bench for eop_line_monitor: run-length reference model checked every cycle,
// directed sequences with literal expectations, then randomized line traffic.
module tb_eop_line_monitor;
  localparam int SE0_MIN = 3;
  localparam int SE0_MAX = 10;
  localparam int J_WIN   = 2;
  localparam int BRC     = 120;

  logic clk48 = 1'b0;
  logic RST   = 1'b0;
  int   nchk  = 0;
  int   nerr  = 0;

  eop_line_monitor_if bus ();

  eop_line_monitor #(
    .SE0_MIN(SE0_MIN), .SE0_MAX(SE0_MAX), .J_WINDOW(J_WIN), .BUS_RESET_CYCLES(BRC)
  ) dut (
    .clk48(clk48),
    .RST  (RST),
    .bus  (bus)
  );

  always #5 clk48 = ~clk48;

  task automatic chk(input string nm, input logic act, input logic exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: length of the current SE0 run and non-J samples since a valid run ended.
  int run = 0;
  int pend = 0;
  bit m_eop = 0, m_pulse = 0, m_err = 0, m_brst = 0;

  always @(posedge clk48 or negedge RST) begin : model
    bit se0, jj, s_eop, s_err;
    if (!RST) begin
      run = 0; pend = 0;
      m_eop = 0; m_pulse = 0; m_err = 0; m_brst = 0;
    end else begin
      se0 = !bus.dataInP && !bus.dataInN;
      jj  =  bus.dataInP && !bus.dataInN;
      s_eop = 0; s_err = 0; m_brst = 0;
      if (pend > 0) begin
        if (jj) s_eop = 1;
        else if (pend == J_WIN) s_err = 1;
        else pend++;
        if (s_eop || s_err) pend = 0;
      end else if (se0) begin
        run++;
        m_brst = (run >= BRC);
      end else if (run > 0) begin
        if (run >= SE0_MIN && run < BRC) begin
          if (run > SE0_MAX) s_err = 1;
          else if (jj) s_eop = 1;
          else pend = 1;
        end
        run = 0;
      end
      m_pulse = s_eop;
      m_eop   = s_eop || (m_eop && !bus.clearFlags);
      m_err   = s_err || (m_err && !bus.clearFlags);
    end
  end

  always @(negedge clk48) begin
    chk("eop", bus.eop, m_eop);
    chk("eopPulse", bus.eopPulse, m_pulse);
    chk("eopErr", bus.eopErr, m_err);
    chk("busReset", bus.busReset, m_brst);
  end

  task automatic step(input logic p, input logic n, input logic clr = 1'b0);
    @(negedge clk48);
    #1;
    bus.dataInP    = p;
    bus.dataInN    = n;
    bus.clearFlags = clr;
  endtask

  task automatic settle();
    @(posedge clk48);
    #1;
  endtask

  task automatic sj(input logic clr = 1'b0); step(1'b1, 1'b0, clr); endtask
  task automatic sk();                       step(1'b0, 1'b1);      endtask
  task automatic se0s(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    bus.dataInP = 1'b1; bus.dataInN = 1'b0; bus.clearFlags = 1'b0;
    repeat (3) @(posedge clk48);
    #1;
    chk("rst_eop", bus.eop, 1'b0);
    chk("rst_err", bus.eopErr, 1'b0);
    chk("rst_brst", bus.busReset, 1'b0);
    @(negedge clk48); #1; RST = 1'b1;

    // minimum-length EOP
    sj(); se0s(3); sj(); settle();
    chk("min_eop", bus.eop, 1'b1);
    chk("min_pulse", bus.eopPulse, 1'b1);
    chk("min_err", bus.eopErr, 1'b0);
    sj(); settle();
    chk("pulse_one_cycle", bus.eopPulse, 1'b0);
    chk("eop_sticky", bus.eop, 1'b1);

    // glitch ignored, then next run counts from 1
    sj(1'b1); se0s(2); sj(); settle();
    chk("glitch_eop", bus.eop, 1'b0);
    chk("glitch_err", bus.eopErr, 1'b0);
    se0s(3); sj(); settle();
    chk("after_glitch_eop", bus.eop, 1'b1);

    // WAIT_J path: K then J, and K K K timeout
    sj(1'b1); se0s(8); sk(); sj(); settle();
    chk("waitj_eop", bus.eop, 1'b1);
    sj(1'b1); se0s(8); sk(); sk(); settle();
    chk("waitj_noerr_yet", bus.eopErr, 1'b0);
    sk(); settle();
    chk("waitj_err", bus.eopErr, 1'b1);
    chk("waitj_no_eop", bus.eop, 1'b0);
    sj(1'b1); se0s(4); sk(); step(1'b0, 1'b0); sj(); settle();
    chk("waitj_se0_nonj_eop", bus.eop, 1'b1);

    // SE0_MAX boundary
    sj(1'b1); se0s(10); sj(); settle();
    chk("max_eop", bus.eop, 1'b1);
    sj(1'b1); se0s(11); sj(); settle();
    chk("over_max_err", bus.eopErr, 1'b1);
    chk("over_max_eop", bus.eop, 1'b0);

    // bus reset
    sj(1'b1); se0s(119); settle();
    chk("brst_119", bus.busReset, 1'b0);
    se0s(1); settle();
    chk("brst_120", bus.busReset, 1'b1);
    se0s(10); settle();
    chk("brst_130", bus.busReset, 1'b1);
    sj(); settle();
    chk("brst_fall", bus.busReset, 1'b0);
    chk("brst_no_eop", bus.eop, 1'b0);
    chk("brst_no_err", bus.eopErr, 1'b0);

    // set beats clear
    se0s(3); sj(); settle();
    se0s(3); sj(1'b1); settle();
    chk("set_wins_eop", bus.eop, 1'b1);
    chk("set_wins_pulse", bus.eopPulse, 1'b1);
    sj(1'b1); settle();
    chk("clear_eop", bus.eop, 1'b0);

    // reset during the 5th SE0 sample
    sj(); se0s(4); step(1'b0, 1'b0);
    #2; RST = 1'b0; #1;
    chk("midrst_eop", bus.eop, 1'b0);
    chk("midrst_pulse", bus.eopPulse, 1'b0);
    chk("midrst_err", bus.eopErr, 1'b0);
    chk("midrst_brst", bus.busReset, 1'b0);
    @(negedge clk48); #1;
    bus.dataInP = 1'b1; bus.dataInN = 1'b0; RST = 1'b1;
    se0s(3); sj(); settle();
    chk("post_rst_eop", bus.eop, 1'b1);

    // randomized traffic
    for (int it = 0; it < 1200; it++) begin
      int len, tail;
      len = ($urandom_range(0, 39) == 0) ? int'($urandom_range(115, 125))
                                         : int'($urandom_range(1, 13));
      for (int i = 0; i < len; i++) step(1'b0, 1'b0, ($urandom_range(0, 15) == 0));
      tail = $urandom_range(0, 4);
      for (int i = 0; i < tail; i++) begin
        int s;
        s = $urandom_range(0, 3);
        case (s)
          0:       step(1'b1, 1'b0, ($urandom_range(0, 15) == 0));
          1:       step(1'b0, 1'b1, ($urandom_range(0, 15) == 0));
          2:       step(1'b0, 1'b0, ($urandom_range(0, 15) == 0));
          default: step(1'b1, 1'b1, ($urandom_range(0, 15) == 0));
        endcase
      end
      if ($urandom_range(0, 1) == 0) sj(($urandom_range(0, 15) == 0));
    end
    settle();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
